// File: rtl/system_pkg.sv
// system_pkg: shared constants for the AHB-Lite timer slice.
// Bus widths, register offsets, CTRL bits, HTRANS/HSIZE codes, bus FSM enum.
// Optional feature macro: TIMER_PRESC_EN (maps the PRESC register).
package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // Word offsets, i.e. haddr[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_COUNT  = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_AR      = 2;
    localparam int STATUS_MATCH = 0;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BUS_OKAY = 2'd0,
        BUS_ERR1 = 2'd1,
        BUS_ERR2 = 2'd2
    } bus_state_t;

    function automatic logic offset_mapped(input logic [2:0] off);
`ifdef TIMER_PRESC_EN
        return off <= OFF_PRESC;
`else
        return off <= OFF_STATUS;
`endif
    endfunction

endpackage

// File: rtl/ahbl_timer_if.sv
// ahbl_timer_if: AHB-Lite slave-side signal bundle for the timer.
// master drives hsel/haddr/htrans/hwrite/hsize/hburst/hprot/hmastlock/hwdata;
// slave drives hreadyout/hresp/hrdata; hready comes from the fabric.
interface ahbl_timer_if #(
    parameter int ADDR_WIDTH = system_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = system_pkg::DATA_WIDTH
);

    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize,
        output hburst, hprot, hmastlock, hwdata,
        input  hready, hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize,
        input  hburst, hprot, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahbl_timer_presc.sv
// ahbl_timer_presc: tick generator for the timer counter.
// Ports: clk, rstn, en (CTRL.EN), presc (TIMER_PRESC_EN only), tick out.
module ahbl_timer_presc (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
`ifdef TIMER_PRESC_EN
    input  logic [31:0] presc,
`endif
    output logic        tick
);

`ifdef TIMER_PRESC_EN
    logic [31:0] cnt;

    // One tick every presc+1 enabled cycles; disabling restarts the period.
    assign tick = en & (cnt == presc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end
`else
    logic unused_clk;

    assign unused_clk = clk ^ rstn;
    assign tick       = en;
`endif

endmodule

// File: rtl/ahbl_timer.sv
// ahbl_timer: AHB-Lite memory-mapped 32-bit timer with compare match IRQ.
// Ports: clk, rstn, ahbl (ahbl_timer_if.slave), irq_o; macro TIMER_PRESC_EN.
module ahbl_timer #(
    parameter int ADDR_WIDTH = system_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = system_pkg::DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rstn,
    ahbl_timer_if.slave ahbl,
    output logic        irq_o
);

    import system_pkg::*;

    logic        accept;
    logic        legal;
    logic        dp_valid;
    logic        dp_write;
    logic [2:0]  dp_off;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        tick;
    logic        hit;
    bus_state_t  state;
    bus_state_t  state_next;
    logic        unused_bus;
`ifdef TIMER_PRESC_EN
    logic        wr_presc;
    logic [31:0] presc;
`endif

    assign unused_bus = ^{ahbl.haddr[ADDR_WIDTH-1:5], ahbl.haddr[1:0],
                          ahbl.htrans[0], ahbl.hburst, ahbl.hprot,
                          ahbl.hmastlock};

    assign accept = ahbl.hsel & ahbl.hready & ahbl.htrans[1];
    assign legal  = (ahbl.hsize == HSIZE_WORD)
                  & offset_mapped(ahbl.haddr[4:2]);

    // Data-phase bookkeeping; only legal transfers become valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= '0;
        end else if (ahbl.hready) begin
            dp_valid <= accept & legal;
            dp_write <= ahbl.hwrite;
            dp_off   <= ahbl.haddr[4:2];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= BUS_OKAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BUS_OKAY: begin
                if (accept && !legal) state_next = BUS_ERR1;
            end
            BUS_ERR1: state_next = BUS_ERR2;
            BUS_ERR2: begin
                state_next = (accept && !legal) ? BUS_ERR1 : BUS_OKAY;
            end
            default:  state_next = BUS_OKAY;
        endcase
    end

    always_comb begin
        ahbl.hreadyout = 1'b1;
        ahbl.hresp     = 1'b0;
        unique case (state)
            BUS_ERR1: begin
                ahbl.hreadyout = 1'b0;
                ahbl.hresp     = 1'b1;
            end
            BUS_ERR2: ahbl.hresp = 1'b1;
            default:  ;
        endcase
    end

    assign wr_en = dp_valid & dp_write & ahbl.hready;
    assign wdata = ahbl.hwdata[31:0];

    always_comb begin
        wr_ctrl   = 1'b0;
        wr_count  = 1'b0;
        wr_cmp    = 1'b0;
        wr_status = 1'b0;
`ifdef TIMER_PRESC_EN
        wr_presc  = 1'b0;
`endif
        if (wr_en) begin
            unique case (dp_off)
                OFF_CTRL:   wr_ctrl   = 1'b1;
                OFF_COUNT:  wr_count  = 1'b1;
                OFF_CMP:    wr_cmp    = 1'b1;
                OFF_STATUS: wr_status = 1'b1;
`ifdef TIMER_PRESC_EN
                OFF_PRESC:  wr_presc  = 1'b1;
`endif
                default:    ;
            endcase
        end
    end

    ahbl_timer_presc u_presc (
        .clk   (clk),
        .rstn  (rstn),
        .en    (ctrl[CTRL_EN]),
`ifdef TIMER_PRESC_EN
        .presc (presc),
`endif
        .tick  (tick)
    );

    // Compare uses the pre-tick COUNT value.
    assign hit = tick & (count == cmp);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl <= '0;
            cmp  <= CMP_RESET;
        end else begin
            if (wr_ctrl) ctrl <= wdata[2:0];
            if (wr_cmp)  cmp  <= wdata;
        end
    end

`ifdef TIMER_PRESC_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (wr_presc) begin
            presc <= wdata;
        end
    end
`endif

    // A bus write to COUNT overrides the tick in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wdata;
        end else if (tick) begin
            count <= (hit && ctrl[CTRL_AR]) ? '0 : count + 32'd1;
        end
    end

    // A new match beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && wdata[STATUS_MATCH]) begin
            match <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= match & ctrl[CTRL_IE];
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid) begin
            unique case (dp_off)
                OFF_CTRL:   rdata = {29'd0, ctrl};
                OFF_COUNT:  rdata = count;
                OFF_CMP:    rdata = cmp;
                OFF_STATUS: rdata = {31'd0, match};
`ifdef TIMER_PRESC_EN
                OFF_PRESC:  rdata = presc;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign ahbl.hrdata = DATA_WIDTH'(rdata);

endmodule

// File: tb/tb_ahbl_timer.sv
// tb_ahbl_timer: directed self-checking bench for ahbl_timer.
// Read data is checked against a queue of expected values.
module tb_ahbl_timer;

    import system_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic irq_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    ahbl_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    assign bus.hready = bus.hreadyout;

    ahbl_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .ahbl  (bus),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.hsel      = 1'b0;
        bus.htrans    = HTRANS_IDLE;
        bus.hwrite    = 1'b0;
        bus.haddr     = '0;
        bus.hsize     = HSIZE_WORD;
    endtask

    task automatic drive_addr(input logic [31:0] addr, input logic wr,
                              input logic [2:0] size);
        bus.hsel   = 1'b1;
        bus.htrans = HTRANS_NONSEQ;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
    endtask

    // Called #1 after the edge that opened a legal read data phase.
    task automatic pop_read(input string tag);
        logic [31:0] e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, bus.hrdata, e);
            check({tag, "_resp"}, {bus.hreadyout, bus.hresp}, 2'b10);
        end
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive_addr(addr, 1'b1, HSIZE_WORD);
        @(posedge clk);
        #1;
        bus_idle();
        bus.hwdata = data;
        @(posedge clk);
    endtask

    task automatic read_reg(input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
        @(negedge clk);
        drive_addr(addr, 1'b0, HSIZE_WORD);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus_idle();
        pop_read(tag);
    endtask

    task automatic err_xfer(input logic [31:0] addr, input logic [2:0] size,
                            input logic wr, input string tag);
        @(negedge clk);
        drive_addr(addr, wr, size);
        @(posedge clk);
        #1;
        bus_idle();
        bus.hwdata = 32'hDEAD_BEEF;
        check({tag, "_err1"}, {bus.hreadyout, bus.hresp}, 2'b01);
        @(posedge clk);
        #1;
        check({tag, "_err2"}, {bus.hreadyout, bus.hresp}, 2'b11);
        @(posedge clk);
        #1;
        check({tag, "_okay"}, {bus.hreadyout, bus.hresp}, 2'b10);
    endtask

    initial begin
        bus_idle();
        bus.hwdata    = '0;
        bus.hburst    = '0;
        bus.hprot     = '0;
        bus.hmastlock = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_hreadyout", bus.hreadyout, 1'b1);
        check("rst_hresp", bus.hresp, 1'b0);
        check("rst_hrdata", bus.hrdata, 32'h0);
        check("rst_irq", irq_o, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        read_reg(32'h00, 32'h0, "rst_ctrl");
        read_reg(32'h04, 32'h0, "rst_count");
        read_reg(32'h08, 32'hFFFF_FFFF, "rst_cmp");
        read_reg(32'h0C, 32'h0, "rst_status");

        // Free-running compare match with IRQ
        write_reg(32'h08, 32'd5);
        write_reg(32'h00, 32'h3);
        repeat (6) @(posedge clk);
        #1;
        check("m_irq_before", irq_o, 1'b0);
        @(posedge clk);
        #1;
        check("m_irq_after", irq_o, 1'b1);
        read_reg(32'h04, 32'd8, "m_count_cont");
        read_reg(32'h0C, 32'h1, "m_status");
        read_reg(32'h00, 32'h3, "m_ctrl");
        write_reg(32'h00, 32'h0);
        read_reg(32'h04, 32'd12, "hold_count_a");
        read_reg(32'h04, 32'd12, "hold_count_b");
        write_reg(32'h0C, 32'h1);
        @(posedge clk);
        #1;
        check("w1c_irq", irq_o, 1'b0);
        read_reg(32'h0C, 32'h0, "w1c_status");

        // Auto-reload
        write_reg(32'h04, 32'd0);
        write_reg(32'h08, 32'd2);
        write_reg(32'h00, 32'h7);
        read_reg(32'h04, 32'd1, "ar_c1");
        read_reg(32'h04, 32'd2, "ar_c2");
        read_reg(32'h04, 32'd0, "ar_c3");
        read_reg(32'h04, 32'd1, "ar_c4");
        read_reg(32'h04, 32'd2, "ar_c5");
        read_reg(32'h04, 32'd0, "ar_c6");
        read_reg(32'h0C, 32'h1, "ar_status");
        check("ar_irq", irq_o, 1'b1);
        write_reg(32'h00, 32'h0);
        write_reg(32'h0C, 32'h1);
        write_reg(32'h04, 32'h55);

        // Error responses
        @(negedge clk);
        drive_addr(32'h04, 1'b0, HSIZE_BYTE);
        @(posedge clk);
        #1;
        check("byte_err1", {bus.hreadyout, bus.hresp}, 2'b01);
        drive_addr(32'h04, 1'b0, HSIZE_WORD);
        exp_q.push_back(32'h55);
        @(posedge clk);
        #1;
        check("byte_err2", {bus.hreadyout, bus.hresp}, 2'b11);
        @(posedge clk);
        #1;
        bus_idle();
        pop_read("byte_next_read");

        err_xfer(32'h04, HSIZE_HALF, 1'b1, "half_wr");
        read_reg(32'h04, 32'h55, "half_no_effect");
        err_xfer(32'h14, HSIZE_WORD, 1'b0, "unmapped_rd");
        err_xfer(32'h1C, HSIZE_WORD, 1'b1, "unmapped_wr");
        read_reg(32'h08, 32'd2, "unmapped_no_effect");
`ifndef TIMER_PRESC_EN
        err_xfer(32'h10, HSIZE_WORD, 1'b0, "presc_absent");
`endif

        // Back-to-back illegal transfers: ERR2 -> ERR1
        @(negedge clk);
        drive_addr(32'h18, 1'b0, HSIZE_WORD);
        @(posedge clk);
        #1;
        check("b2b_e1", {bus.hreadyout, bus.hresp}, 2'b01);
        drive_addr(32'h00, 1'b0, HSIZE_BYTE);
        @(posedge clk);
        #1;
        check("b2b_e2", {bus.hreadyout, bus.hresp}, 2'b11);
        @(posedge clk);
        #1;
        bus_idle();
        check("b2b_e1_again", {bus.hreadyout, bus.hresp}, 2'b01);
        @(posedge clk);
        #1;
        check("b2b_e2_again", {bus.hreadyout, bus.hresp}, 2'b11);
        @(posedge clk);
        #1;
        check("b2b_okay", {bus.hreadyout, bus.hresp}, 2'b10);

        // Wrap and write-vs-tick priority
        write_reg(32'h08, 32'h100);
        write_reg(32'h00, 32'h1);
        write_reg(32'h04, 32'hFFFF_FFFF);
        read_reg(32'h04, 32'd0, "wrap_zero");
        read_reg(32'h04, 32'd1, "wrap_one");
        write_reg(32'h04, 32'h1234);
        read_reg(32'h04, 32'h1235, "wr_beats_tick");

        // Match coinciding with W1C
        write_reg(32'h00, 32'h0);
        write_reg(32'h04, 32'd0);
        write_reg(32'h08, 32'd3);
        write_reg(32'h00, 32'h3);
        repeat (8) @(posedge clk);
        read_reg(32'h0C, 32'h1, "pre_match");
        check("pre_irq", irq_o, 1'b1);
        write_reg(32'h00, 32'h2);
        write_reg(32'h04, 32'd0);
        write_reg(32'h00, 32'h3);
        repeat (2) @(posedge clk);
        write_reg(32'h0C, 32'h1);
        #1;
        check("race_irq_a", irq_o, 1'b1);
        @(posedge clk);
        #1;
        check("race_irq_b", irq_o, 1'b1);
        read_reg(32'h0C, 32'h1, "race_status");

        // Reset in the middle of a CMP write
        @(negedge clk);
        drive_addr(32'h08, 1'b1, HSIZE_WORD);
        @(posedge clk);
        #1;
        bus_idle();
        bus.hwdata = 32'h77;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_hreadyout", bus.hreadyout, 1'b1);
        check("mid_rst_hresp", bus.hresp, 1'b0);
        check("mid_rst_hrdata", bus.hrdata, 32'h0);
        check("mid_rst_irq", irq_o, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        read_reg(32'h08, 32'hFFFF_FFFF, "mid_rst_cmp");
        read_reg(32'h04, 32'h0, "mid_rst_count");
        read_reg(32'h00, 32'h0, "mid_rst_ctrl");
        read_reg(32'h0C, 32'h0, "mid_rst_status");

        // Unused bits
        write_reg(32'h00, 32'hFFFF_FFF8);
        read_reg(32'h00, 32'h0, "ctrl_unused");
        read_reg(32'h04, 32'h0, "ctrl_unused_count");

`ifdef TIMER_PRESC_EN
        // Prescaled tick: one increment every 4 cycles
        read_reg(32'h10, 32'h0, "presc_rst");
        write_reg(32'h10, 32'd3);
        write_reg(32'h00, 32'h1);
        read_reg(32'h04, 32'd0, "presc_c1");
        read_reg(32'h04, 32'd0, "presc_c2");
        read_reg(32'h04, 32'd0, "presc_c3");
        read_reg(32'h04, 32'd1, "presc_c4");
        read_reg(32'h04, 32'd1, "presc_c5");
        read_reg(32'h04, 32'd1, "presc_c6");
        read_reg(32'h04, 32'd1, "presc_c7");
        read_reg(32'h04, 32'd2, "presc_c8");
        read_reg(32'h10, 32'd3, "presc_rd");
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("presc_rst_hrdata", bus.hrdata, 32'h0);
        check("presc_rst_irq", irq_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        read_reg(32'h10, 32'h0, "presc_after_rst");
        read_reg(32'h04, 32'h0, "presc_count_after_rst");
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahbl_timer.md
AHBL_TIMER -- requirements
Module: ahbl_timer

Interface
REQ-001 Parameter ADDR_WIDTH, default ADDR_WIDTH from system_pkg (32), width of the HADDR bus.
REQ-002 Parameter DATA_WIDTH, default DATA_WIDTH from system_pkg (32), width of the HRDATA/HWDATA buses.
REQ-003 clk  in  1  the single clock; all logic is rising-edge.
REQ-004 rstn  in  1  reset; asynchronous assert, active-low.
REQ-005 ahbl_hsel  in  1  slave select from the data fabric decoder.
REQ-006 ahbl_haddr  in  ADDR_WIDTH  address; only bits [4:0] are decoded.
REQ-007 ahbl_htrans  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-008 ahbl_hwrite  in  1  1 = write.
REQ-009 ahbl_hsize  in  3  transfer size; only 3'b010 (word) is legal.
REQ-010 ahbl_hburst, ahbl_hprot, ahbl_hmastlock  in  3/4/1  accepted and ignored.
REQ-011 ahbl_hwdata  in  DATA_WIDTH  write data, sampled in the data phase.
REQ-012 ahbl_hready  in  1  bus-wide ready.
REQ-013 ahbl_hreadyout  out  1  slave ready.
REQ-014 ahbl_hresp  out  1  0 = OKAY, 1 = ERROR.
REQ-015 ahbl_hrdata  out  DATA_WIDTH  read data, data phase.
REQ-016 irq_o  out  1  level interrupt, registered.

Function
REQ-017 An address phase is accepted when hsel & hready & htrans[1]; addr[4:2], hwrite and a legal flag are then registered for the data phase.
REQ-018 Register map (word offsets): 0x00 CTRL {bit0 EN, bit1 IE, bit2 AUTORELOAD}; 0x04 COUNT (RW); 0x08 CMP (RW); 0x0C STATUS {bit0 MATCH, write-1-to-clear}; 0x10 PRESC (RW, only when TIMER_PRESC_EN is defined).
REQ-019 A legal transfer completes with zero wait states: hreadyout=1 and hresp=0 in the data phase; a write updates the register at the end of the data phase; hrdata is driven from the registered offset in the data phase.
REQ-020 Unused bits read 0; writes to them are ignored.
REQ-021 An illegal transfer (hsize != word, or an unmapped offset) produces a two-cycle ERROR response with no register side effects.
REQ-022 Bus FSM has three states: OKAY, ERR1 and ERR2.
REQ-023 OKAY -> ERR1 when an illegal transfer is accepted.
REQ-024 ERR1 drives hreadyout=0 and hresp=1, then moves to ERR2.
REQ-025 ERR2 drives hreadyout=1 and hresp=1, then moves to OKAY, or back to ERR1 if another illegal transfer is accepted in the same cycle.
REQ-026 Tick: asserted every clk while EN=1; with TIMER_PRESC_EN, asserted once every PRESC+1 cycles while EN=1.
REQ-027 On each tick, COUNT increments modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-028 On a tick with COUNT==CMP, MATCH is set; if AUTORELOAD=1, COUNT loads 0 instead of incrementing.
REQ-029 A bus write to COUNT in the same cycle as a tick wins.
REQ-030 A match in the same cycle as a W1C of MATCH wins (MATCH stays 1).
REQ-031 irq_o = registered (MATCH & IE); it changes one cycle after MATCH or IE changes.
REQ-032 Clearing EN holds COUNT and resets the prescaler counter to 0.

Reset
REQ-033 While rstn=0, the following are held: CTRL=0, COUNT=0, CMP=0xFFFFFFFF, MATCH=0, PRESC=0, prescaler counter=0, FSM=OKAY, data-phase registers invalid, hreadyout=1, hresp=0, hrdata=0, irq_o=0.
REQ-034 Reset asserted mid-transfer aborts the transfer with no register write.

Configuration
REQ-035 Macro TIMER_PRESC_EN: when defined, the PRESC register and a 32-bit prescaler counter exist, and the tick period is PRESC+1 cycles.
REQ-036 When TIMER_PRESC_EN is undefined, the tick equals EN and offset 0x10 is unmapped (ERROR response).

Structure
REQ-037 system_pkg holds the register offset constants, CTRL bit indices, the HTRANS/HSIZE encodings and the FSM state enum.
REQ-038 Sub-module ahbl_timer_presc holds the prescaler counter and tick generation; all else is in ahbl_timer.

Verification
REQ-039 Write CMP=5, CTRL=0x3, then idle -> MATCH=1 on the tick where COUNT==5; irq_o=1 one cycle later; COUNT continues 6, 7, ...
REQ-040 CTRL=0x7, CMP=2 -> COUNT sequence 0,1,2,0,1,2; MATCH set on the first COUNT==2 tick.
REQ-041 Read with hsize=byte at 0x04, then a legal read -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1, then OKAY with correct data.
REQ-042 Write COUNT=0xFFFFFFFF with EN=1 -> next tick COUNT=0; a same-cycle COUNT write and tick -> the written value wins.
REQ-043 W1C of MATCH in the same cycle as a new match -> MATCH remains 1, irq_o stays high.
REQ-044 With TIMER_PRESC_EN and PRESC=3 -> COUNT increments every 4th cycle; rstn pulsed low mid-count -> all outputs take reset values.
